// File: rtl/filtro_distancia_pkg.sv
// filtro_distancia_pkg: shared state type, default thresholds and width helper
// for the echo-distance filter.
`timescale 1ns/1ps
package filtro_distancia_pkg;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } estado_t;

  localparam int          DEF_DATAWIDTH   = 16;
  localparam int          DEF_LOG2_N      = 2;
  localparam logic [15:0] DEF_MAX_VALID   = 16'hF000;
  localparam logic [15:0] DEF_NEAR_TH     = 16'd1200;
  localparam logic [15:0] DEF_FAR_TH      = 16'd1500;
  localparam int          DEF_TIMEOUT_CYC = 2000000;

  // The running sum holds 2^log2_n samples, so it needs log2_n extra bits.
  function automatic int sumw(input int datawidth, input int log2_n);
    return datawidth + log2_n;
  endfunction

endpackage

// File: rtl/filtro_ventana.sv
// filtro_ventana: circular sample buffer with running sum and fill count.
// A push replaces the oldest slot; a flush empties the window.
`timescale 1ns/1ps
module filtro_ventana
  import filtro_distancia_pkg::*;
#(
  parameter int DATAWIDTH = DEF_DATAWIDTH,
  parameter int LOG2_N    = DEF_LOG2_N,
  localparam int SUMW     = sumw(DATAWIDTH, LOG2_N)
)(
  input  logic                 FiltroVentana_Clock,
  input  logic                 FiltroVentana_Reset,
  input  logic                 FiltroVentana_Push,
  input  logic                 FiltroVentana_Flush,
  input  logic [DATAWIDTH-1:0] FiltroVentana_Muestra_In,
  output logic [SUMW-1:0]      FiltroVentana_Suma_Out,
  output logic [LOG2_N:0]      FiltroVentana_Llenado_Out
);

  localparam int             N     = 1 << LOG2_N;
  localparam logic [LOG2_N:0] LLENO = N[LOG2_N:0];

  logic [DATAWIDTH-1:0] ventana [N];
  logic [LOG2_N-1:0]    ptr;
  logic [SUMW-1:0]      suma;
  logic [LOG2_N:0]      llenado;

  // Replace the oldest slot and keep the running sum in step with the buffer contents
  always_ff @(posedge FiltroVentana_Clock or posedge FiltroVentana_Reset) begin
    if (FiltroVentana_Reset) begin
      for (int i = 0; i < N; i++) ventana[i] <= '0;
      ptr     <= '0;
      suma    <= '0;
      llenado <= '0;
    end else if (FiltroVentana_Flush) begin
      for (int i = 0; i < N; i++) ventana[i] <= '0;
      ptr     <= '0;
      suma    <= '0;
      llenado <= '0;
    end else if (FiltroVentana_Push) begin
      ventana[ptr] <= FiltroVentana_Muestra_In;
      suma         <= suma + SUMW'(FiltroVentana_Muestra_In) - SUMW'(ventana[ptr]);
      ptr          <= ptr + 1'b1;
      if (llenado != LLENO) llenado <= llenado + 1'b1;
    end
  end

  assign FiltroVentana_Suma_Out    = suma;
  assign FiltroVentana_Llenado_Out = llenado;

endmodule

// File: rtl/filtro_distancia.sv
// filtro_distancia: captures echo counts on trigger edges, rejects outliers,
// averages over a 2^LOG2_N window, and drives obstacle/timeout/error status.
`timescale 1ns/1ps
module filtro_distancia
  import filtro_distancia_pkg::*;
#(
  parameter int                   DATAWIDTH   = DEF_DATAWIDTH,
  parameter int                   LOG2_N      = DEF_LOG2_N,
  parameter logic [DATAWIDTH-1:0] MAX_VALID   = DEF_MAX_VALID,
  parameter logic [DATAWIDTH-1:0] NEAR_TH     = DEF_NEAR_TH,
  parameter logic [DATAWIDTH-1:0] FAR_TH      = DEF_FAR_TH,
  parameter int                   TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
  input  logic                 FiltroDistancia_Clock,
  input  logic                 FiltroDistancia_Reset,
  input  logic [DATAWIDTH-1:0] FiltroDistancia_Conteo_In,
  input  logic                 FiltroDistancia_Trigger_In,
  output logic [DATAWIDTH-1:0] FiltroDistancia_Promedio_Out,
  output logic                 FiltroDistancia_Valido_Out,
  output logic                 FiltroDistancia_Obstaculo_Out,
  output logic                 FiltroDistancia_Timeout_Out,
  output logic [7:0]           FiltroDistancia_Errores_Out
);

  localparam int              SUMW           = sumw(DATAWIDTH, LOG2_N);
  localparam int              TW             = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TIMER_MAX      = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0]   TIMER_PRE      = TW'(TIMEOUT_CYC - 2);
  localparam int              ULTIMO         = (1 << LOG2_N) - 1;
  localparam logic [LOG2_N:0] ULTIMO_LLENADO = ULTIMO[LOG2_N:0];

  logic                 trig_q;
  logic [DATAWIDTH-1:0] samp_q;
  logic                 etapa1_q;
  logic                 etapa2_q;
  estado_t              estado_q;
  estado_t              estado_sig;
  logic [TW-1:0]        timer_q;
  logic [SUMW-1:0]      suma;
  logic [LOG2_N:0]      llenado;
  logic [DATAWIDTH-1:0] promedio_q;
  logic                 valido_q;
  logic                 obstaculo_q;
  logic                 timeout_q;
  logic [7:0]           errores_q;

  logic                 strobe;
  logic                 ocupado;
  logic                 aceptada;
  logic                 rechazada;
  logic                 descartada;
  logic                 timeout_evt;
  logic [DATAWIDTH-1:0] promedio_nuevo;
  logic [8:0]           errores_ext;

  assign strobe         = FiltroDistancia_Trigger_In & ~trig_q;
  assign ocupado        = etapa1_q | etapa2_q;
  assign aceptada       = etapa1_q && (samp_q != '0) && (samp_q <= MAX_VALID);
  assign rechazada      = etapa1_q && !aceptada;
  assign descartada     = strobe && ocupado;
  assign timeout_evt    = !strobe && (timer_q == TIMER_PRE);
  assign promedio_nuevo = DATAWIDTH'(suma >> LOG2_N);
  assign errores_ext    = {1'b0, errores_q} + 9'(rechazada) + 9'(descartada);

  filtro_ventana #(
    .DATAWIDTH (DATAWIDTH),
    .LOG2_N    (LOG2_N)
  ) u_ventana (
    .FiltroVentana_Clock       (FiltroDistancia_Clock),
    .FiltroVentana_Reset       (FiltroDistancia_Reset),
    .FiltroVentana_Push        (aceptada),
    .FiltroVentana_Flush       (timeout_evt),
    .FiltroVentana_Muestra_In  (samp_q),
    .FiltroVentana_Suma_Out    (suma),
    .FiltroVentana_Llenado_Out (llenado)
  );

  // Edge-detect the trigger, latch the count and track the two pipeline stages
  always_ff @(posedge FiltroDistancia_Clock or posedge FiltroDistancia_Reset) begin
    if (FiltroDistancia_Reset) begin
      trig_q   <= 1'b0;
      samp_q   <= '0;
      etapa1_q <= 1'b0;
      etapa2_q <= 1'b0;
    end else begin
      trig_q   <= FiltroDistancia_Trigger_In;
      if (strobe) samp_q <= FiltroDistancia_Conteo_In;
      etapa1_q <= strobe && !ocupado;
      etapa2_q <= aceptada;
    end
  end

  // FSM state register
  always_ff @(posedge FiltroDistancia_Clock or posedge FiltroDistancia_Reset) begin
    if (FiltroDistancia_Reset) estado_q <= FILL;
    else                       estado_q <= estado_sig;
  end

  // Leave FILL once the window holds a full set of samples; a timeout restarts filling
  always_comb begin
    estado_sig = estado_q;
    if (timeout_evt) begin
      estado_sig = FILL;
    end else if (estado_q == FILL && aceptada && llenado == ULTIMO_LLENADO) begin
      estado_sig = RUN;
    end
  end

  // Silence timer restarts on every strobe; the flag drops again on the next good sample
  always_ff @(posedge FiltroDistancia_Clock or posedge FiltroDistancia_Reset) begin
    if (FiltroDistancia_Reset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (strobe)                  timer_q <= '0;
      else if (timer_q != TIMER_MAX) timer_q <= timer_q + 1'b1;
      if (timeout_evt)   timeout_q <= 1'b1;
      else if (aceptada) timeout_q <= 1'b0;
    end
  end

  // Publish the average and update the hysteretic obstacle flag on each emitted result
  always_ff @(posedge FiltroDistancia_Clock or posedge FiltroDistancia_Reset) begin
    if (FiltroDistancia_Reset) begin
      promedio_q  <= '0;
      valido_q    <= 1'b0;
      obstaculo_q <= 1'b0;
    end else begin
      valido_q <= 1'b0;
      if (timeout_evt) begin
        obstaculo_q <= 1'b0;
      end else if (etapa2_q && estado_q == RUN) begin
        valido_q   <= 1'b1;
        promedio_q <= promedio_nuevo;
        if (promedio_nuevo < NEAR_TH)     obstaculo_q <= 1'b1;
        else if (promedio_nuevo > FAR_TH) obstaculo_q <= 1'b0;
      end
    end
  end

  // Saturating count of rejected and dropped samples (both can occur in one cycle)
  always_ff @(posedge FiltroDistancia_Clock or posedge FiltroDistancia_Reset) begin
    if (FiltroDistancia_Reset) errores_q <= '0;
    else                       errores_q <= errores_ext[8] ? 8'hFF : errores_ext[7:0];
  end

  assign FiltroDistancia_Promedio_Out  = promedio_q;
  assign FiltroDistancia_Valido_Out    = valido_q;
  assign FiltroDistancia_Obstaculo_Out = obstaculo_q;
  assign FiltroDistancia_Timeout_Out   = timeout_q;
  assign FiltroDistancia_Errores_Out   = errores_q;

endmodule
